// File: rtl/stack_cpu_pkg.sv
// Shared encodings for the stack-machine controller: opcodes, FSM states,
// ALU operation codes, ALU-A source selects and the packed strobe bundle.
package stack_cpu_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_NOT  = 3'b011;
    localparam logic [2:0] OP_PUSH = 3'b100;
    localparam logic [2:0] OP_POP  = 3'b101;
    localparam logic [2:0] OP_JMP  = 3'b110;
    localparam logic [2:0] OP_JZ   = 3'b111;

    typedef enum logic [3:0] {
        S_IF     = 4'd0,
        S_ID     = 4'd1,
        S_POP1   = 4'd2,
        S_POP2   = 4'd3,
        S_LDB    = 4'd4,
        S_LDA    = 4'd5,
        S_TOSRD  = 4'd6,
        S_EXEC   = 4'd7,
        S_WB     = 4'd8,
        S_MEMRD  = 4'd9,
        S_PUSHWB = 4'd10,
        S_MEMWR  = 4'd11,
        S_JMP    = 4'd12,
        S_BRZ    = 4'd13
    } state_t;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;

    localparam logic [1:0] SRCA_PC = 2'b00;
    localparam logic [1:0] SRCA_FF = 2'b01;
    localparam logic [1:0] SRCA_A  = 2'b10;

    typedef struct packed {
        logic       push;
        logic       pop;
        logic       tos;
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       stack_src;
        logic       ld_a;
        logic       ld_b;
        logic [1:0] alu_src_a;
        logic       alu_src_b;
        logic       pc_src;
        logic [1:0] alu_ctrl;
    } ctrl_t;

    function automatic logic is_arith(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND);
    endfunction

endpackage

// File: rtl/stack_ctrl_decode.sv
// Combinational Moore decode: current state -> datapath strobes.
// The opcode only matters in EXEC, where it picks the ALU operation.
module stack_ctrl_decode
    import stack_cpu_pkg::*;
(
    input  state_t     state,
    input  logic [2:0] opc,
    output ctrl_t      ctrl
);

    // Strobe table; everything not named in a state stays low
    always_comb begin
        ctrl = '0;
        case (state)
            S_IF: begin
                ctrl.mem_read  = 1'b1;
                ctrl.ir_write  = 1'b1;
                ctrl.alu_src_a = SRCA_PC;
                ctrl.alu_src_b = 1'b1;
                ctrl.alu_ctrl  = ALU_ADD;
                ctrl.pc_write  = 1'b1;
            end
            S_ID:    ctrl = '0;
            S_POP1:  ctrl.pop = 1'b1;
            S_POP2: begin
                ctrl.pop  = 1'b1;
                ctrl.ld_b = 1'b1;
            end
            S_LDB:   ctrl.ld_b = 1'b1;
            S_LDA:   ctrl.ld_a = 1'b1;
            S_TOSRD: ctrl.tos  = 1'b1;
            S_EXEC: begin
                ctrl.alu_src_b = 1'b0;
                case (opc)
                    OP_SUB: begin
                        ctrl.alu_src_a = SRCA_A;
                        ctrl.alu_ctrl  = ALU_SUB;
                    end
                    OP_AND: begin
                        ctrl.alu_src_a = SRCA_A;
                        ctrl.alu_ctrl  = ALU_AND;
                    end
                    // 255 - B is the bitwise complement of B
                    OP_NOT: begin
                        ctrl.alu_src_a = SRCA_FF;
                        ctrl.alu_ctrl  = ALU_SUB;
                    end
                    default: begin
                        ctrl.alu_src_a = SRCA_A;
                        ctrl.alu_ctrl  = ALU_ADD;
                    end
                endcase
            end
            S_WB:    ctrl.push = 1'b1;
            S_MEMRD: begin
                ctrl.iord     = 1'b1;
                ctrl.mem_read = 1'b1;
            end
            S_PUSHWB: begin
                ctrl.stack_src = 1'b1;
                ctrl.push      = 1'b1;
            end
            S_MEMWR: begin
                ctrl.iord      = 1'b1;
                ctrl.mem_write = 1'b1;
            end
            S_JMP: begin
                ctrl.pc_src   = 1'b1;
                ctrl.pc_write = 1'b1;
            end
            S_BRZ: begin
                ctrl.pc_src        = 1'b1;
                ctrl.pc_write_cond = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/stack_cpu_controller.sv
// Multicycle control FSM for the 8-bit stack machine: state register,
// opcode-driven next-state logic, and reset gating of the decoded strobes.
module stack_cpu_controller
    import stack_cpu_pkg::*;
#(
    parameter int OPC_W   = 3,
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [OPC_W-1:0]   opc,
    output logic               push,
    output logic               pop,
    output logic               tos,
    output logic               pc_write,
    output logic               pc_write_cond,
    output logic               iord,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic               stack_src,
    output logic               ld_a,
    output logic               ld_b,
    output logic [1:0]         alu_src_a,
    output logic               alu_src_b,
    output logic               pc_src,
    output logic [1:0]         alu_ctrl,
    output logic [STATE_W-1:0] state_o
);

    state_t state;
    state_t state_next;
    ctrl_t  ctrl;
    ctrl_t  ctrl_out;

    // State register; reset aborts any instruction and restarts at fetch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IF;
        end else begin
            state <= state_next;
        end
    end

    // Next-state selection; unused encodings fall back to fetch
    always_comb begin
        state_next = S_IF;
        case (state)
            S_IF: state_next = S_ID;
            S_ID: begin
                if (!opc[2]) begin
                    state_next = S_POP1;
                end else begin
                    case (opc)
                        OP_PUSH: state_next = S_MEMRD;
                        OP_POP:  state_next = S_POP1;
                        OP_JMP:  state_next = S_JMP;
                        default: state_next = S_TOSRD;
                    endcase
                end
            end
            S_POP1: begin
                if (is_arith(opc)) begin
                    state_next = S_POP2;
                end else if (opc == OP_NOT) begin
                    state_next = S_LDB;
                end else if (opc == OP_POP) begin
                    state_next = S_LDA;
                end else begin
                    state_next = S_IF;
                end
            end
            S_POP2:  state_next = S_LDA;
            S_LDB:   state_next = S_EXEC;
            S_LDA: begin
                if (is_arith(opc)) begin
                    state_next = S_EXEC;
                end else if (opc == OP_POP) begin
                    state_next = S_MEMWR;
                end else if (opc == OP_JZ) begin
                    state_next = S_BRZ;
                end else begin
                    state_next = S_IF;
                end
            end
            S_TOSRD:  state_next = S_LDA;
            S_EXEC:   state_next = S_WB;
            S_MEMRD:  state_next = S_PUSHWB;
            default:  state_next = S_IF;
        endcase
    end

    stack_ctrl_decode u_decode (
        .state (state),
        .opc   (opc),
        .ctrl  (ctrl)
    );

    // No strobe may reach the datapath while reset is held
    always_comb begin
        if (rst) begin
            ctrl_out = '0;
            state_o  = '0;
        end else begin
            ctrl_out = ctrl;
            state_o  = state;
        end
    end

    assign push          = ctrl_out.push;
    assign pop           = ctrl_out.pop;
    assign tos           = ctrl_out.tos;
    assign pc_write      = ctrl_out.pc_write;
    assign pc_write_cond = ctrl_out.pc_write_cond;
    assign iord          = ctrl_out.iord;
    assign mem_read      = ctrl_out.mem_read;
    assign mem_write     = ctrl_out.mem_write;
    assign ir_write      = ctrl_out.ir_write;
    assign stack_src     = ctrl_out.stack_src;
    assign ld_a          = ctrl_out.ld_a;
    assign ld_b          = ctrl_out.ld_b;
    assign alu_src_a     = ctrl_out.alu_src_a;
    assign alu_src_b     = ctrl_out.alu_src_b;
    assign pc_src        = ctrl_out.pc_src;
    assign alu_ctrl      = ctrl_out.alu_ctrl;

endmodule
